do_change_rx_ctrl: RTL and testbench

Receive-side control for VR DoViewChange messages at the incoming leader. Accepts parsed DoViewChange metadata and log payload from the UDP receive path and deduplicates senders by replica index. Tracks the best log (highest last-normal view, then highest op number) and steers only that log into the log writer; all other payloads are drained. Once a configurable quorum is reached, it presents the chosen view/op/commit to the StartView sender.

---
 rtl/do_change_rx_ctrl_pkg.sv | 20 ++
 rtl/do_change_best_sel.sv | 113 +++++++++++
 rtl/do_change_rx_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_do_change_rx_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/do_change_rx_ctrl_pkg.sv
// Shared definitions for the DoViewChange receive controller:
// default sizing, derived index/count widths and the FSM state encoding.
package do_change_rx_ctrl_pkg;

    localparam int NUM_REPLICAS_DEF = 8;
    localparam int VIEW_W_DEF       = 64;
    localparam int OP_W_DEF         = 64;
    localparam int REPLICA_W_DEF    = $clog2(NUM_REPLICAS_DEF);
    localparam int CNT_W_DEF        = $clog2(NUM_REPLICAS_DEF + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_META,
        ST_CHECK,
        ST_STORE_LOG,
        ST_DRAIN,
        ST_QUORUM
    } state_e;

endpackage

// File: rtl/do_change_best_sel.sv
// Vote bookkeeping for one DoViewChange collection round: decides whether the
// registered message is accepted (right view, valid index, new sender) and
// whether its log beats the current best, and holds the seen bitmap, vote
// count and best lnv/op/commit registers.
module do_change_best_sel
    import do_change_rx_ctrl_pkg::*;
#(
    parameter  int NUM_REPLICAS = NUM_REPLICAS_DEF,
    parameter  int VIEW_W       = VIEW_W_DEF,
    parameter  int OP_W         = OP_W_DEF,
    localparam int REPLICA_W    = $clog2(NUM_REPLICAS),
    localparam int CNT_W        = $clog2(NUM_REPLICAS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_i,
    input  logic                 eval_i,
    input  logic [REPLICA_W-1:0] self_idx_i,
    input  logic [VIEW_W-1:0]    self_lnv_i,
    input  logic [OP_W-1:0]      self_op_i,
    input  logic [OP_W-1:0]      self_commit_i,
    input  logic [VIEW_W-1:0]    round_view_i,
    input  logic [VIEW_W-1:0]    meta_view_i,
    input  logic [VIEW_W-1:0]    meta_lnv_i,
    input  logic [OP_W-1:0]      meta_op_i,
    input  logic [OP_W-1:0]      meta_commit_i,
    input  logic [REPLICA_W-1:0] meta_src_idx_i,
    output logic                 accepted_o,
    output logic                 better_o,
    output logic                 dup_o,
    output logic                 view_mis_o,
    output logic [CNT_W-1:0]     count_after_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [OP_W-1:0]      best_op_o,
    output logic [OP_W-1:0]      best_commit_o
);

    // Bitmap spans the full index encoding so out-of-range indices never index past it.
    localparam int SPAN = 1 << REPLICA_W;

    logic [SPAN-1:0]   idx_ok;
    logic [SPAN-1:0]   seen_q, seen_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [VIEW_W-1:0] best_lnv_q, best_lnv_d;
    logic [OP_W-1:0]   best_op_q, best_op_d;
    logic [OP_W-1:0]   best_commit_q, best_commit_d;

    for (genvar g = 0; g < SPAN; g++) begin : g_idx_ok
        assign idx_ok[g] = (g < NUM_REPLICAS);
    end

    assign view_mis_o = (meta_view_i != round_view_i);
    assign dup_o      = !view_mis_o && idx_ok[meta_src_idx_i] && seen_q[meta_src_idx_i];
    assign accepted_o = !view_mis_o && idx_ok[meta_src_idx_i] && !seen_q[meta_src_idx_i];
    assign better_o   = accepted_o &&
                        ((meta_lnv_i > best_lnv_q) ||
                         ((meta_lnv_i == best_lnv_q) && (meta_op_i > best_op_q)));

    // Count including the message under evaluation; saturates at the replica count.
    assign count_after_o = (accepted_o && (count_q < CNT_W'(NUM_REPLICAS))) ?
                           count_q + CNT_W'(1) : count_q;

    assign count_o       = count_q;
    assign best_op_o     = best_op_q;
    assign best_commit_o = best_commit_q;

    // Next-state for the round bookkeeping: seeded with own values, then merged per message.
    always_comb begin
        seen_d        = seen_q;
        count_d       = count_q;
        best_lnv_d    = best_lnv_q;
        best_op_d     = best_op_q;
        best_commit_d = best_commit_q;
        if (init_i) begin
            seen_d             = '0;
            seen_d[self_idx_i] = 1'b1;
            count_d            = CNT_W'(1);
            best_lnv_d         = self_lnv_i;
            best_op_d          = self_op_i;
            best_commit_d      = self_commit_i;
        end else if (eval_i) begin
            count_d = count_after_o;
            if (accepted_o) begin
                seen_d[meta_src_idx_i] = 1'b1;
                if (meta_commit_i > best_commit_q) begin
                    best_commit_d = meta_commit_i;
                end
            end
            if (better_o) begin
                best_lnv_d = meta_lnv_i;
                best_op_d  = meta_op_i;
            end
        end
    end

    // Round bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q        <= '0;
            count_q       <= '0;
            best_lnv_q    <= '0;
            best_op_q     <= '0;
            best_commit_q <= '0;
        end else begin
            seen_q        <= seen_d;
            count_q       <= count_d;
            best_lnv_q    <= best_lnv_d;
            best_op_q     <= best_op_d;
            best_commit_q <= best_commit_d;
        end
    end

endmodule

// File: rtl/do_change_rx_ctrl.sv
// Receive-side DoViewChange control at the incoming leader. Collects votes,
// steers the best log into the log writer, drains the rest, and offers the
// chosen view/op/commit once the quorum is met.
// Optional: define DO_CHANGE_RX_STATS_EN to add drop/round statistics counters.
//
// state     | meaning
// IDLE      | waiting for begin_collect
// WAIT_META | accepting the next DoViewChange metadata
// CHECK     | one-cycle accept/better evaluation of registered metadata
// STORE_LOG | forwarding the best log's beats to the log writer
// DRAIN     | consuming and discarding a non-best log
// QUORUM    | presenting the chosen view/op/commit until taken
module do_change_rx_ctrl
    import do_change_rx_ctrl_pkg::*;
#(
    parameter  int NUM_REPLICAS = NUM_REPLICAS_DEF,
    parameter  int VIEW_W       = VIEW_W_DEF,
    parameter  int OP_W         = OP_W_DEF,
    localparam int REPLICA_W    = $clog2(NUM_REPLICAS),
    localparam int CNT_W        = $clog2(NUM_REPLICAS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 begin_collect,
    input  logic [VIEW_W-1:0]    cur_view,
    input  logic [CNT_W-1:0]     quorum_size,
    input  logic [REPLICA_W-1:0] self_idx,
    input  logic [VIEW_W-1:0]    self_lnv,
    input  logic [OP_W-1:0]      self_op,
    input  logic [OP_W-1:0]      self_commit,
    output logic                 collect_rdy,
    input  logic                 udp_do_change_meta_val,
    output logic                 do_change_udp_meta_rdy,
    input  logic [VIEW_W-1:0]    meta_view,
    input  logic [VIEW_W-1:0]    meta_lnv,
    input  logic [OP_W-1:0]      meta_op,
    input  logic [OP_W-1:0]      meta_commit,
    input  logic [REPLICA_W-1:0] meta_src_idx,
    input  logic                 meta_log_empty,
    input  logic                 udp_do_change_data_val,
    input  logic                 udp_do_change_data_last,
    output logic                 do_change_udp_data_rdy,
    output logic                 log_wr_start,
    output logic                 log_wr_data_val,
    output logic                 log_wr_data_last,
    input  logic                 log_wr_data_rdy,
    output logic                 quorum_val,
    input  logic                 quorum_rdy,
    output logic [VIEW_W-1:0]    quorum_view,
    output logic [OP_W-1:0]      quorum_op,
    output logic [OP_W-1:0]      quorum_commit
`ifdef DO_CHANGE_RX_STATS_EN
    ,
    output logic [31:0]          stat_dup_drops,
    output logic [31:0]          stat_view_drops,
    output logic [31:0]          stat_rounds
`endif
);

    state_e                state_q;
    logic [VIEW_W-1:0]     view_q;
    logic [VIEW_W-1:0]     m_view_q;
    logic [VIEW_W-1:0]     m_lnv_q;
    logic [OP_W-1:0]       m_op_q;
    logic [OP_W-1:0]       m_commit_q;
    logic [REPLICA_W-1:0]  m_src_q;
    logic                  m_empty_q;

    logic                  init;
    logic                  eval;
    logic                  accepted;
    logic                  better;
    logic                  dup;
    logic                  view_mis;
    logic [CNT_W-1:0]      count_after;
    logic [CNT_W-1:0]      count;
    logic [OP_W-1:0]       best_op;
    logic [OP_W-1:0]       best_commit;
    logic                  store_last_hs;
    logic                  drain_last_hs;

    assign init = (state_q == ST_IDLE) && begin_collect;
    assign eval = (state_q == ST_CHECK);

    assign store_last_hs = (state_q == ST_STORE_LOG) && udp_do_change_data_val &&
                           log_wr_data_rdy && udp_do_change_data_last;
    assign drain_last_hs = (state_q == ST_DRAIN) && udp_do_change_data_val &&
                           udp_do_change_data_last;

    do_change_best_sel #(
        .NUM_REPLICAS (NUM_REPLICAS),
        .VIEW_W       (VIEW_W),
        .OP_W         (OP_W)
    ) u_best_sel (
        .clk            (clk),
        .rst            (rst),
        .init_i         (init),
        .eval_i         (eval),
        .self_idx_i     (self_idx),
        .self_lnv_i     (self_lnv),
        .self_op_i      (self_op),
        .self_commit_i  (self_commit),
        .round_view_i   (view_q),
        .meta_view_i    (m_view_q),
        .meta_lnv_i     (m_lnv_q),
        .meta_op_i      (m_op_q),
        .meta_commit_i  (m_commit_q),
        .meta_src_idx_i (m_src_q),
        .accepted_o     (accepted),
        .better_o       (better),
        .dup_o          (dup),
        .view_mis_o     (view_mis),
        .count_after_o  (count_after),
        .count_o        (count),
        .best_op_o      (best_op),
        .best_commit_o  (best_commit)
    );

    // Round sequencing; metadata is registered so CHECK compares stable values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            view_q     <= '0;
            m_view_q   <= '0;
            m_lnv_q    <= '0;
            m_op_q     <= '0;
            m_commit_q <= '0;
            m_src_q    <= '0;
            m_empty_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (begin_collect) begin
                        view_q  <= cur_view;
                        state_q <= (quorum_size <= CNT_W'(1)) ? ST_QUORUM : ST_WAIT_META;
                    end
                end
                ST_WAIT_META: begin
                    if (udp_do_change_meta_val) begin
                        m_view_q   <= meta_view;
                        m_lnv_q    <= meta_lnv;
                        m_op_q     <= meta_op;
                        m_commit_q <= meta_commit;
                        m_src_q    <= meta_src_idx;
                        m_empty_q  <= meta_log_empty;
                        state_q    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!m_empty_q) begin
                        state_q <= better ? ST_STORE_LOG : ST_DRAIN;
                    end else begin
                        state_q <= (count_after >= quorum_size) ? ST_QUORUM : ST_WAIT_META;
                    end
                end
                ST_STORE_LOG: begin
                    if (store_last_hs) begin
                        state_q <= (count >= quorum_size) ? ST_QUORUM : ST_WAIT_META;
                    end
                end
                ST_DRAIN: begin
                    if (drain_last_hs) begin
                        state_q <= (count >= quorum_size) ? ST_QUORUM : ST_WAIT_META;
                    end
                end
                ST_QUORUM: begin
                    if (quorum_rdy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign collect_rdy            = (state_q == ST_IDLE);
    assign do_change_udp_meta_rdy = (state_q == ST_WAIT_META);
    assign do_change_udp_data_rdy = ((state_q == ST_STORE_LOG) && log_wr_data_rdy) ||
                                    (state_q == ST_DRAIN);
    assign log_wr_start           = eval && better;
    assign log_wr_data_val        = (state_q == ST_STORE_LOG) && udp_do_change_data_val;
    assign log_wr_data_last       = (state_q == ST_STORE_LOG) && udp_do_change_data_last;
    assign quorum_val             = (state_q == ST_QUORUM);
    assign quorum_view            = view_q;
    assign quorum_op              = best_op;
    assign quorum_commit          = best_commit;

`ifdef DO_CHANGE_RX_STATS_EN
    logic [31:0] stat_dup_q;
    logic [31:0] stat_view_q;
    logic [31:0] stat_rounds_q;
    logic        unused_accepted;

    assign unused_accepted = accepted;

    // Drop and round counters; wrap naturally, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dup_q    <= '0;
            stat_view_q   <= '0;
            stat_rounds_q <= '0;
        end else begin
            if (eval && dup) begin
                stat_dup_q <= stat_dup_q + 32'd1;
            end
            if (eval && view_mis) begin
                stat_view_q <= stat_view_q + 32'd1;
            end
            if ((state_q == ST_QUORUM) && quorum_rdy) begin
                stat_rounds_q <= stat_rounds_q + 32'd1;
            end
        end
    end

    assign stat_dup_drops  = stat_dup_q;
    assign stat_view_drops = stat_view_q;
    assign stat_rounds     = stat_rounds_q;
`else
    logic unused_stats;
    assign unused_stats = ^{dup, view_mis, accepted};
`endif

endmodule

// File: tb/tb_do_change_rx_ctrl.sv
// Scoreboard bench for do_change_rx_ctrl: directed rounds push hand-computed
// expected events (log_wr_start, log beats, quorum result) into a queue and
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_do_change_rx_ctrl;

    localparam int EV_START  = 0;
    localparam int EV_BEAT   = 1;
    localparam int EV_QUORUM = 2;

    typedef struct {
        int          kind;
        logic        last;
        logic [63:0] view;
        logic [63:0] op;
        logic [63:0] commit;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        begin_collect;
    logic [63:0] cur_view;
    logic [3:0]  quorum_size;
    logic [2:0]  self_idx;
    logic [63:0] self_lnv, self_op, self_commit;
    logic        collect_rdy;
    logic        udp_do_change_meta_val;
    logic        do_change_udp_meta_rdy;
    logic [63:0] meta_view, meta_lnv, meta_op, meta_commit;
    logic [2:0]  meta_src_idx;
    logic        meta_log_empty;
    logic        udp_do_change_data_val;
    logic        udp_do_change_data_last;
    logic        do_change_udp_data_rdy;
    logic        log_wr_start;
    logic        log_wr_data_val;
    logic        log_wr_data_last;
    logic        log_wr_data_rdy = 1'b1;
    logic        quorum_val;
    logic        quorum_rdy;
    logic [63:0] quorum_view, quorum_op, quorum_commit;
`ifdef DO_CHANGE_RX_STATS_EN
    logic [31:0] stat_dup_drops, stat_view_drops, stat_rounds;
`endif

    int  n_cmp = 0;
    int  n_err = 0;
    bit  toggle_en = 1'b0;
    ev_t exp_q[$];

    do_change_rx_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .begin_collect           (begin_collect),
        .cur_view                (cur_view),
        .quorum_size             (quorum_size),
        .self_idx                (self_idx),
        .self_lnv                (self_lnv),
        .self_op                 (self_op),
        .self_commit             (self_commit),
        .collect_rdy             (collect_rdy),
        .udp_do_change_meta_val  (udp_do_change_meta_val),
        .do_change_udp_meta_rdy  (do_change_udp_meta_rdy),
        .meta_view               (meta_view),
        .meta_lnv                (meta_lnv),
        .meta_op                 (meta_op),
        .meta_commit             (meta_commit),
        .meta_src_idx            (meta_src_idx),
        .meta_log_empty          (meta_log_empty),
        .udp_do_change_data_val  (udp_do_change_data_val),
        .udp_do_change_data_last (udp_do_change_data_last),
        .do_change_udp_data_rdy  (do_change_udp_data_rdy),
        .log_wr_start            (log_wr_start),
        .log_wr_data_val         (log_wr_data_val),
        .log_wr_data_last        (log_wr_data_last),
        .log_wr_data_rdy         (log_wr_data_rdy),
        .quorum_val              (quorum_val),
        .quorum_rdy              (quorum_rdy),
        .quorum_view             (quorum_view),
        .quorum_op               (quorum_op),
        .quorum_commit           (quorum_commit)
`ifdef DO_CHANGE_RX_STATS_EN
        ,
        .stat_dup_drops          (stat_dup_drops),
        .stat_view_drops         (stat_view_drops),
        .stat_rounds             (stat_rounds)
`endif
    );

    always #5 clk = ~clk;

    // Log writer backpressure: steady ready, or alternating when toggle_en is set.
    always @(posedge clk) begin
        #1;
        if (toggle_en) log_wr_data_rdy = ~log_wr_data_rdy;
        else           log_wr_data_rdy = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic check_event(input int kind, input logic last,
                               input logic [63:0] v, input logic [63:0] o, input logic [63:0] c);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        if (kind == e.kind) begin
            if (kind == EV_BEAT) chk("beat_last", 64'(last), 64'(e.last));
            if (kind == EV_QUORUM) begin
                chk("quorum_view", v, e.view);
                chk("quorum_op", o, e.op);
                chk("quorum_commit", c, e.commit);
            end
        end
    endtask

    // Monitor: compare every DUT-presented event against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (log_wr_start) check_event(EV_START, 1'b0, '0, '0, '0);
            if (log_wr_data_val && log_wr_data_rdy)
                check_event(EV_BEAT, log_wr_data_last, '0, '0, '0);
            if (quorum_val && quorum_rdy)
                check_event(EV_QUORUM, 1'b0, quorum_view, quorum_op, quorum_commit);
        end
    end

    task automatic exp_start();
        ev_t e;
        e = '{kind: EV_START, last: 1'b0, view: '0, op: '0, commit: '0};
        exp_q.push_back(e);
    endtask

    task automatic exp_beats(input int n, input bit final_last);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e = '{kind: EV_BEAT, last: (final_last && i == n - 1), view: '0, op: '0, commit: '0};
            exp_q.push_back(e);
        end
    endtask

    task automatic exp_quorum(input logic [63:0] v, input logic [63:0] o, input logic [63:0] c);
        ev_t e;
        e = '{kind: EV_QUORUM, last: 1'b0, view: v, op: o, commit: c};
        exp_q.push_back(e);
    endtask

    task automatic start_round(input logic [63:0] v, input logic [3:0] q, input logic [2:0] si,
                               input logic [63:0] sl, input logic [63:0] so, input logic [63:0] sc);
        int t;
        cur_view = v; quorum_size = q; self_idx = si;
        self_lnv = sl; self_op = so; self_commit = sc;
        t = 0;
        while (!collect_rdy && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!collect_rdy) fail_to("collect_rdy");
        begin_collect = 1'b1;
        @(posedge clk); #1;
        begin_collect = 1'b0;
    endtask

    task automatic send_meta(input logic [63:0] v, input logic [63:0] l, input logic [63:0] o,
                             input logic [63:0] c, input logic [2:0] src, input logic empty);
        int t;
        bit hs;
        meta_view = v; meta_lnv = l; meta_op = o; meta_commit = c;
        meta_src_idx = src; meta_log_empty = empty;
        udp_do_change_meta_val = 1'b1;
        t = 0;
        do begin
            @(negedge clk); hs = do_change_udp_meta_rdy;
            @(posedge clk); #1; t++;
        end while (!hs && t < 50);
        udp_do_change_meta_val = 1'b0;
        if (!hs) fail_to("meta_handshake");
    endtask

    task automatic send_data(input int n, input bit final_last);
        int t;
        bit hs;
        for (int i = 0; i < n; i++) begin
            udp_do_change_data_val  = 1'b1;
            udp_do_change_data_last = final_last && (i == n - 1);
            t = 0;
            do begin
                @(negedge clk); hs = do_change_udp_data_rdy;
                @(posedge clk); #1; t++;
            end while (!hs && t < 50);
            if (!hs) fail_to("data_handshake");
        end
        udp_do_change_data_val  = 1'b0;
        udp_do_change_data_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (exp_q.size() != 0) fail_to(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; begin_collect = 1'b0; cur_view = '0; quorum_size = '0;
        self_idx = '0; self_lnv = '0; self_op = '0; self_commit = '0;
        udp_do_change_meta_val = 1'b0; meta_view = '0; meta_lnv = '0; meta_op = '0;
        meta_commit = '0; meta_src_idx = '0; meta_log_empty = 1'b0;
        udp_do_change_data_val = 1'b0; udp_do_change_data_last = 1'b0; quorum_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_collect_rdy", 64'(collect_rdy), 64'd1);
        chk("rst_meta_rdy", 64'(do_change_udp_meta_rdy), 64'd0);
        chk("rst_data_rdy", 64'(do_change_udp_data_rdy), 64'd0);
        chk("rst_log_wr_start", 64'(log_wr_start), 64'd0);
        chk("rst_log_wr_val", 64'(log_wr_data_val), 64'd0);
        chk("rst_log_wr_last", 64'(log_wr_data_last), 64'd0);
        chk("rst_quorum_val", 64'(quorum_val), 64'd0);
        chk("rst_quorum_view", quorum_view, 64'd0);
        chk("rst_quorum_op", quorum_op, 64'd0);
        chk("rst_quorum_commit", quorum_commit, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round 1: idx1 best (stored), idx2 worse (drained); quorum op 12, commit max 9.
        start_round(64'd5, 4'd3, 3'd0, 64'd2, 64'd10, 64'd7);
        exp_start(); exp_beats(4, 1'b1);
        send_meta(64'd5, 64'd2, 64'd12, 64'd9, 3'd1, 1'b0);
        @(negedge clk);
        chk("check_meta_rdy", 64'(do_change_udp_meta_rdy), 64'd0);
        chk("check_data_rdy", 64'(do_change_udp_data_rdy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("store_data_rdy_2cyc", 64'(do_change_udp_data_rdy), 64'd1);
        @(posedge clk); #1;
        send_data(4, 1'b1);
        exp_quorum(64'd5, 64'd12, 64'd9);
        send_meta(64'd5, 64'd2, 64'd11, 64'd8, 3'd2, 1'b0);
        send_data(3, 1'b1);
        wait_drain("round1_drain");

        // Round 2: duplicate and wrong-view messages must not count or alter state.
        start_round(64'd6, 4'd3, 3'd0, 64'd1, 64'd3, 64'd1);
        exp_start(); exp_beats(2, 1'b1);
        send_meta(64'd6, 64'd1, 64'd4, 64'd2, 3'd1, 1'b0);
        send_data(2, 1'b1);
        send_meta(64'd6, 64'd5, 64'd9, 64'd50, 3'd1, 1'b0);
        send_data(2, 1'b1);
        send_meta(64'd7, 64'd9, 64'd9, 64'd60, 3'd2, 1'b0);
        send_data(1, 1'b1);
        @(negedge clk);
        chk("no_quorum_after_drops", 64'(quorum_val), 64'd0);
        chk("meta_rdy_after_drops", 64'(do_change_udp_meta_rdy), 64'd1);
        @(posedge clk); #1;
        exp_quorum(64'd6, 64'd4, 64'd4);
        send_meta(64'd6, 64'd1, 64'd2, 64'd4, 3'd2, 1'b1);
        wait_drain("round2_drain");

        // Round 3: higher lnv wins over higher op; writer backpressure toggles; quorum stalls.
        start_round(64'd9, 4'd3, 3'd3, 64'd2, 64'd50, 64'd20);
        exp_start(); exp_beats(4, 1'b1);
        send_meta(64'd9, 64'd3, 64'd5, 64'd10, 3'd1, 1'b0);
        toggle_en = 1'b1;
        send_data(4, 1'b1);
        toggle_en = 1'b0;
        quorum_rdy = 1'b0;
        exp_quorum(64'd9, 64'd5, 64'd30);
        send_meta(64'd9, 64'd2, 64'd60, 64'd30, 3'd5, 1'b1);
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!quorum_val && t < 20);
        if (!quorum_val) fail_to("quorum_val");
        for (int i = 0; i < 5; i++) begin
            chk("stall_quorum_val", 64'(quorum_val), 64'd1);
            chk("stall_quorum_view", quorum_view, 64'd9);
            chk("stall_quorum_op", quorum_op, 64'd5);
            chk("stall_quorum_commit", quorum_commit, 64'd30);
            @(negedge clk);
        end
        @(posedge clk); #1;
        quorum_rdy = 1'b1;
        wait_drain("round3_drain");

        // Round 4: reset in the middle of a stored log abandons the round.
        start_round(64'd2, 4'd2, 3'd0, 64'd0, 64'd0, 64'd0);
        exp_start(); exp_beats(2, 1'b0);
        send_meta(64'd2, 64'd1, 64'd1, 64'd1, 3'd1, 1'b0);
        send_data(2, 1'b0);
        udp_do_change_data_val = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_collect_rdy", 64'(collect_rdy), 64'd1);
        chk("midrst_meta_rdy", 64'(do_change_udp_meta_rdy), 64'd0);
        chk("midrst_data_rdy", 64'(do_change_udp_data_rdy), 64'd0);
        chk("midrst_log_wr_val", 64'(log_wr_data_val), 64'd0);
        @(posedge clk); #1;
        udp_do_change_data_val = 1'b0;
        rst = 1'b0;
        chk("midrst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Round 5: clean restart, quorum of 2 with one empty-log better vote.
        start_round(64'd3, 4'd2, 3'd0, 64'd0, 64'd7, 64'd3);
        exp_start(); exp_quorum(64'd3, 64'd8, 64'd3);
        send_meta(64'd3, 64'd0, 64'd8, 64'd1, 3'd2, 1'b1);
        wait_drain("round5_drain");

        // Round 6: quorum of 1 goes straight to the result with own values.
        exp_quorum(64'd4, 64'd7, 64'd3);
        start_round(64'd4, 4'd1, 3'd0, 64'd0, 64'd7, 64'd3);
        wait_drain("round6_drain");

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
